s2p_converter: RTL

- Serial-to-parallel converter. Collects N serial bits, MSB first, into one N-bit parallel word.
- Serial side uses a valid/ready handshake. Parallel side uses a valid/ready handshake.
- Receive-side counterpart of the team's parallel-to-serial converter: a word it serialises comes out here bit-identical.
- A one-word output register decouples the sides, so the next word can be collected while the downstream consumer stalls.

---
 rtl/s2p_converter.sv | 95 +++++++++
 1 files changed

// File: rtl/s2p_converter.sv
// s2p_converter: collects N serial bits (MSB first) into an N-bit word.
// The serial and parallel sides each use a valid/ready handshake. A one-word
// output register lets the next word be collected while the consumer stalls.
// If a second word completes while the output register is still full, it is
// parked in the shift register (HOLD) until the consumer frees the output.
module s2p_converter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_valid,
  input  logic         ser_data,
  output logic         ser_ready,
  output logic         par_valid,
  output logic [N-1:0] par_data,
  input  logic         par_ready
);

  localparam int              CW       = $clog2(N);
  localparam logic [0:0]      ST_SHIFT = 1'b0;
  localparam logic [0:0]      ST_HOLD  = 1'b1;
  localparam logic [CW-1:0]   LAST     = CW'(N - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_out;
  logic          r_out_full;

  logic          w_accept;
  logic          w_last;
  logic          w_drain;
  logic [N-1:0]  w_word;

  // ser_ready depends only on registered state and reset, never on par_ready
  assign ser_ready = (r_state == ST_SHIFT) && !rst;
  assign par_valid = r_out_full;
  assign par_data  = r_out;

  // Handshake qualifiers and the word formed if this bit completes it
  always_comb begin
    w_accept = ser_valid && (r_state == ST_SHIFT);
    w_last   = (r_count == LAST);
    w_drain  = r_out_full && par_ready;
    w_word   = {r_shift[N-2:0], ser_data};
  end

  // Bit collection, output buffering and the SHIFT/HOLD overflow state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_SHIFT;
      r_count    <= '0;
      r_shift    <= '0;
      r_out      <= '0;
      r_out_full <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          // A plain drain empties the output; a completing word below overrides it
          if (w_drain) begin
            r_out_full <= 1'b0;
          end
          if (w_accept) begin
            if (!w_last) begin
              r_shift <= w_word;
              r_count <= r_count + CW'(1);
            end else begin
              r_count <= '0;
              if (!r_out_full || par_ready) begin
                // Output is free, or is being drained on this same edge
                r_out      <= w_word;
                r_out_full <= 1'b1;
              end else begin
                // Output still occupied: park the finished word
                r_shift <= w_word;
                r_state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          // Output is full here; hand the parked word over as soon as it drains
          if (par_ready) begin
            r_out   <= r_shift;
            r_state <= ST_SHIFT;
          end
        end
        default: begin
          r_state <= ST_SHIFT;
        end
      endcase
    end
  end

endmodule
